// File: rtl/svnet_pipeline_free_space_manager_if.sv
// svnet_pipeline_free_space_manager_if: producer/sink credit bus around the free-space manager
interface svnet_pipeline_free_space_manager_if #(
   parameter int DEPTH = 16,
   parameter int DELAY = 4
);
   localparam int FW = $clog2(DEPTH) + 1;
   localparam int CW = $clog2(DELAY + 1);
   logic [FW-1:0] sink_free_space;
   logic          sink_write;
   logic [FW-1:0] pipeline_free_space;
   logic          pipeline_write;
   logic [CW-1:0] in_flight;
   logic          overflow_error;
   logic          underflow_error;
   logic          clear_error;
   modport master (
      output sink_free_space, pipeline_write, clear_error,
      input  sink_write, pipeline_free_space, in_flight, overflow_error, underflow_error
   );
   modport slave (
      input  sink_free_space, pipeline_write, clear_error,
      output sink_write, pipeline_free_space, in_flight, overflow_error, underflow_error
   );
endinterface

// File: rtl/svnet_pipeline_free_space_manager.sv
// svnet_pipeline_free_space_manager: delays producer writes to the sink and reports credit net of in-flight writes
module svnet_pipeline_free_space_manager #(
   parameter int DEPTH = 16,
   parameter int DELAY = 4
) (
   input logic                            clk,
   input logic                            rst_n,
   svnet_pipeline_free_space_manager_if.slave bus
);
   localparam int FW = $clog2(DEPTH) + 1;
   localparam int CW = $clog2(DELAY + 1);
   logic [DELAY-1:0] line;
   logic [CW-1:0]    in_flight;
   logic             starved;
   logic             accept;
   logic             overflow_error;
   logic             underflow_error;
   // Credit seen by the producer; clamps to zero when the sink lost space behind our back
   always_comb begin
      starved                 = 32'(in_flight) > 32'(bus.sink_free_space);
      bus.pipeline_free_space = starved ? '0 : bus.sink_free_space - FW'(in_flight);
      accept                  = bus.pipeline_write && (bus.pipeline_free_space != '0);
   end
   assign bus.sink_write      = line[DELAY-1];
   assign bus.in_flight       = in_flight;
   assign bus.overflow_error  = overflow_error;
   assign bus.underflow_error = underflow_error;
   // Valid line and in-flight count; reset discards everything still travelling
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         line      <= '0;
         in_flight <= '0;
      end else begin
         line[0] <= accept;
         for (int i = 1; i < DELAY; i++) line[i] <= line[i-1];
         in_flight <= in_flight + CW'(accept) - CW'(line[DELAY-1]);
      end
   end
   // Sticky error flags; a new violation wins over a simultaneous clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow_error  <= 1'b0;
         underflow_error <= 1'b0;
      end else begin
         overflow_error  <= (bus.pipeline_write && bus.pipeline_free_space == '0) || (overflow_error && !bus.clear_error);
         underflow_error <= starved || (underflow_error && !bus.clear_error);
      end
   end
   a_count_matches_line : assert property (@(posedge clk) disable iff (!rst_n) 32'(in_flight) == $countones(line));
   a_arrival_has_room   : assert property (@(posedge clk) disable iff (!rst_n) bus.sink_write |-> bus.sink_free_space != '0);
endmodule
